// File: rtl/pkt_job_ctrl.sv
// pkt_job_ctrl: runs one packet-builder -> packet-parser round trip per accepted job and
// returns a status word. Define PKT_JOB_WDOG_EN to enable the per-phase watchdog.
module pkt_job_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [17:0] cmd_cfg,
  output logic        pb_start,
  input  logic        pb_busy,
  input  logic        pb_irq,
  output logic [31:0] pb_addr_in,
  output logic [16:0] pb_cfg,
  input  logic [31:0] pb_addr_out,
  output logic        pp_start,
  input  logic        pp_busy,
  input  logic        pp_irq,
  output logic [31:0] pp_addr_hdr,
  output logic        pp_ignore_ecc_err,
  input  logic [2:0]  pp_pkt_flags,
  input  logic [3:0]  pp_pkt_byte_cnt,
  input  logic [3:0]  pp_pkt_type,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_status,
  output logic [31:0] res_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PB_LAUNCH,
    S_PB_WAIT,
    S_PP_LAUNCH,
    S_PP_WAIT,
    S_RESULT
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("pkt_job_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  state_t      r_state;
  logic [31:0] r_pb_addr_in;
  logic [16:0] r_pb_cfg;
  logic        r_pp_ignore;
  logic        r_pb_start;
  logic        r_pp_start;
  logic [31:0] r_pp_addr_hdr;
  logic        r_res_valid;
  logic [7:0]  r_res_status;
  logic [31:0] r_res_addr;

  logic [2:0]  w_exp_flags;
  logic [7:0]  w_pp_status;
  logic        w_wdog_expired;

  // Flags the parser should report given what the job asked the builder to inject.
  assign w_exp_flags[0] = r_pb_cfg[8] && (r_pb_cfg[11:10] == 2'b01);
  assign w_exp_flags[1] = r_pb_cfg[8] && r_pb_cfg[11];
  assign w_exp_flags[2] = r_pb_cfg[9] && r_pb_cfg[12];

  assign w_pp_status = {2'b00,
                        (w_exp_flags != pp_pkt_flags),
                        (pp_pkt_type != r_pb_cfg[7:4]),
                        (pp_pkt_byte_cnt != r_pb_cfg[3:0]),
                        pp_pkt_flags};

`ifdef PKT_JOB_WDOG_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES);
  logic [WDOG_W-1:0] r_wdog;

  assign w_wdog_expired = (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  // Cleared while launching, so each WAIT phase starts counting from zero.
  always_ff @(posedge clk) begin
    if (reset || r_state == S_PB_LAUNCH || r_state == S_PP_LAUNCH) begin
      r_wdog <= '0;
    end else if (r_state == S_PB_WAIT || r_state == S_PP_WAIT) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  assign w_wdog_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pb_addr_in  <= '0;
      r_pb_cfg      <= '0;
      r_pp_ignore   <= 1'b0;
      r_pb_start    <= 1'b0;
      r_pp_start    <= 1'b0;
      r_pp_addr_hdr <= '0;
      r_res_valid   <= 1'b0;
      r_res_status  <= '0;
      r_res_addr    <= '0;
    end else begin
      r_pb_start <= 1'b0;
      r_pp_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_pb_addr_in <= cmd_addr;
            r_pb_cfg     <= cmd_cfg[16:0];
            r_pp_ignore  <= cmd_cfg[17];
            r_pb_start   <= !pb_busy;
            r_state      <= S_PB_LAUNCH;
          end
        end
        // The start pulse is decided one cycle ahead, so LAUNCH exits once it is out.
        S_PB_LAUNCH: begin
          if (r_pb_start) r_state <= S_PB_WAIT;
          else            r_pb_start <= !pb_busy;
        end
        S_PB_WAIT: begin
          if (pb_irq) begin
            r_pp_addr_hdr <= pb_addr_out;
            r_res_addr    <= pb_addr_out;
            r_pp_start    <= !pp_busy;
            r_state       <= S_PP_LAUNCH;
          end else if (w_wdog_expired) begin
            r_res_status <= 8'h40;
            r_res_addr   <= '0;
            r_res_valid  <= 1'b1;
            r_state      <= S_RESULT;
          end
        end
        S_PP_LAUNCH: begin
          if (r_pp_start) r_state <= S_PP_WAIT;
          else            r_pp_start <= !pp_busy;
        end
        S_PP_WAIT: begin
          if (pp_irq) begin
            r_res_status <= w_pp_status;
            r_res_valid  <= 1'b1;
            r_state      <= S_RESULT;
          end else if (w_wdog_expired) begin
            r_res_status <= 8'hC0;
            r_res_valid  <= 1'b1;
            r_state      <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready         = (r_state == S_IDLE) && !reset;
  assign pb_start          = r_pb_start;
  assign pb_addr_in        = r_pb_addr_in;
  assign pb_cfg            = r_pb_cfg;
  assign pp_start          = r_pp_start;
  assign pp_addr_hdr       = r_pp_addr_hdr;
  assign pp_ignore_ecc_err = r_pp_ignore;
  assign res_valid         = r_res_valid;
  assign res_status        = r_res_status;
  assign res_addr          = r_res_addr;

endmodule

// File: tb/tb_pkt_job_ctrl.sv
// Testbench for pkt_job_ctrl: scripted pb/pp engine responses, scoreboard of expected results.
module tb_pkt_job_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [17:0] cmd_cfg;
  logic        pb_start, pb_busy, pb_irq;
  logic [31:0] pb_addr_in, pb_addr_out;
  logic [16:0] pb_cfg;
  logic        pp_start, pp_busy, pp_irq;
  logic [31:0] pp_addr_hdr;
  logic        pp_ignore_ecc_err;
  logic [2:0]  pp_pkt_flags;
  logic [3:0]  pp_pkt_byte_cnt, pp_pkt_type;
  logic        res_valid, res_ready;
  logic [7:0]  res_status;
  logic [31:0] res_addr;

  int n_chk = 0;
  int n_fail = 0;
  int j_acc, j_pbs, j_pbi, j_pps, j_ppi, j_rv, j_pb_cnt, j_pp_cnt;

  typedef struct packed {
    logic [7:0]  st;
    logic [31:0] ad;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pkt_job_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_cfg(cmd_cfg),
    .pb_start(pb_start), .pb_busy(pb_busy), .pb_irq(pb_irq), .pb_addr_in(pb_addr_in),
    .pb_cfg(pb_cfg), .pb_addr_out(pb_addr_out),
    .pp_start(pp_start), .pp_busy(pp_busy), .pp_irq(pp_irq), .pp_addr_hdr(pp_addr_hdr),
    .pp_ignore_ecc_err(pp_ignore_ecc_err), .pp_pkt_flags(pp_pkt_flags),
    .pp_pkt_byte_cnt(pp_pkt_byte_cnt), .pp_pkt_type(pp_pkt_type),
    .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status), .res_addr(res_addr)
  );

  function automatic logic [7:0] model_status(logic [17:0] cfg, logic [2:0] fl,
                                              logic [3:0] cnt, logic [3:0] typ);
    logic [2:0] ef;
    ef[0] = cfg[8] && (cfg[11:10] == 2'b01);
    ef[1] = cfg[8] && cfg[11];
    ef[2] = cfg[9] && cfg[12];
    return {2'b00, (ef != fl), (typ != cfg[7:4]), (cnt != cfg[3:0]), fl};
  endfunction

  // Cycle-stepped job: offers the command, plays pb then pp, returns on res_valid
  // (or early inside PP_WAIT when stop_pp is set). Event cycles land in j_*.
  task automatic run_job(input logic [31:0] addr, input logic [17:0] cfg, input logic [31:0] hdr,
                         input int pbb, input int ppb, input logic [2:0] fl,
                         input logic [3:0] cnt, input logic [3:0] typ,
                         input bit pb_ans, input bit pp_ans, input bit stop_pp, input int budget);
    j_acc = -1; j_pbs = -1; j_pbi = -1; j_pps = -1; j_ppi = -1; j_rv = -1;
    j_pb_cnt = 0; j_pp_cnt = 0;
    cmd_addr = addr;
    cmd_cfg  = cfg;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (pb_start === 1'b1) begin j_pb_cnt++; if (j_pbs < 0) j_pbs = c; end
      if (pp_start === 1'b1) begin j_pp_cnt++; if (j_pps < 0) j_pps = c; end
      if (stop_pp && j_pps >= 0 && c == j_pps + 3) begin
        pb_irq = 1'b0; pp_irq = 1'b0; cmd_valid = 1'b0; pb_busy = 1'b0; pp_busy = 1'b0;
        break;
      end
      cmd_valid = (j_acc < 0);
      if (cmd_valid && cmd_ready === 1'b1) j_acc = c;
      pb_busy = (j_acc >= 0 && j_pbs < 0 && c < j_acc + pbb);
      pb_irq  = pb_ans && j_pbs >= 0 && j_pbi < 0 && c == j_pbs + 3;
      pb_addr_out = pb_irq ? hdr : 32'hDEAD_BEEF;
      if (pb_irq) j_pbi = c;
      pp_busy = (j_pbi >= 0 && j_pps < 0 && c < j_pbi + ppb);
      pp_irq  = pp_ans && j_pps >= 0 && j_ppi < 0 && c == j_pps + 2;
      pp_pkt_flags    = pp_irq ? fl  : ~fl;
      pp_pkt_byte_cnt = pp_irq ? cnt : ~cnt;
      pp_pkt_type     = pp_irq ? typ : ~typ;
      if (pp_irq) j_ppi = c;
      if (res_valid === 1'b1) begin j_rv = c; break; end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic take_result(output logic [7:0] st, output logic [31:0] ad, output bit ok);
    ok = (res_valid === 1'b1);
    st = res_status;
    ad = res_addr;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready); end
    n_chk++; if ({pb_start, pp_start, res_valid, pp_ignore_ecc_err} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b, required 0000", {pb_start, pp_start, res_valid, pp_ignore_ecc_err}); end
    n_chk++; if (pb_addr_in !== 0 || pb_cfg !== 0 || pp_addr_hdr !== 0 || res_status !== 0 || res_addr !== 0) begin n_fail++; $display("FAIL reset_data: got %h %h %h %h %h, required all 0", pb_addr_in, pb_cfg, pp_addr_hdr, res_status, res_addr); end
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_idle: cmd_ready %b, required 1", cmd_ready); end
  endtask

  task automatic test_clean();
    exp_t e; logic [7:0] st; logic [31:0] ad; bit ok;
    sb.push_back('{8'h00, 32'h0000_0200});
    run_job(32'h100, 18'h00338, 32'h200, 0, 0, 3'b000, 4'd8, 4'd3, 1'b1, 1'b1, 1'b0, 200);
    n_chk++; if (j_acc < 0 || j_pbs !== j_acc + 1) begin n_fail++; $display("FAIL clean_pb_start_cycle: got %0d, required %0d", j_pbs, j_acc + 1); end
    n_chk++; if (j_pbi < 0 || j_pps !== j_pbi + 1) begin n_fail++; $display("FAIL clean_pp_start_cycle: got %0d, required %0d", j_pps, j_pbi + 1); end
    n_chk++; if (j_ppi < 0 || j_rv !== j_ppi + 1) begin n_fail++; $display("FAIL clean_res_valid_cycle: got %0d, required %0d", j_rv, j_ppi + 1); end
    n_chk++; if (pb_addr_in !== 32'h100 || pb_cfg !== 17'h00338 || pp_ignore_ecc_err !== 1'b0) begin n_fail++; $display("FAIL clean_pb_regs: got %h %h %b, required 00000100 00338 0", pb_addr_in, pb_cfg, pp_ignore_ecc_err); end
    n_chk++; if (pp_addr_hdr !== 32'h200) begin n_fail++; $display("FAIL clean_pp_addr_hdr: got %h, required 00000200", pp_addr_hdr); end
    take_result(st, ad, ok);
    e = sb.pop_front();
    n_chk++; if (!ok || st !== e.st || ad !== e.ad) begin n_fail++; $display("FAIL clean_result: valid %0d status %h addr %h, required status %h addr %h", ok, st, ad, e.st, e.ad); end
    $display("clean job: status %h addr %h", st, ad);
  endtask

  task automatic test_inject();
    exp_t e; logic [7:0] st; logic [31:0] ad; bit ok;
    sb.push_back('{8'h05, 32'h0000_0210});
    run_job(32'h110, 18'h01738, 32'h210, 0, 0, 3'b101, 4'd8, 4'd3, 1'b1, 1'b1, 1'b0, 200);
    take_result(st, ad, ok);
    e = sb.pop_front();
    n_chk++; if (!ok || st !== e.st || ad !== e.ad) begin n_fail++; $display("FAIL inject_expected: valid %0d status %h addr %h, required status %h addr %h", ok, st, ad, e.st, e.ad); end
    $display("inject job pp flags 101: status %h", st);
    sb.push_back('{8'h21, 32'h0000_0220});
    run_job(32'h120, 18'h21738, 32'h220, 0, 0, 3'b001, 4'd8, 4'd3, 1'b1, 1'b1, 1'b0, 200);
    n_chk++; if (pp_ignore_ecc_err !== 1'b1 || pb_cfg !== 17'h01738) begin n_fail++; $display("FAIL inject_cfg_regs: got ignore %b cfg %h, required 1 01738", pp_ignore_ecc_err, pb_cfg); end
    take_result(st, ad, ok);
    e = sb.pop_front();
    n_chk++; if (!ok || st !== e.st || ad !== e.ad) begin n_fail++; $display("FAIL inject_unexpected: valid %0d status %h addr %h, required status %h addr %h", ok, st, ad, e.st, e.ad); end
    $display("inject job pp flags 001: status %h", st);
  endtask

  task automatic test_mismatch();
    exp_t e; logic [7:0] st; logic [31:0] ad; bit ok;
    sb.push_back('{8'h18, 32'h0000_0230});
    run_job(32'h130, 18'h00338, 32'h230, 0, 0, 3'b000, 4'd7, 4'd2, 1'b1, 1'b1, 1'b0, 200);
    take_result(st, ad, ok);
    e = sb.pop_front();
    n_chk++; if (!ok || st !== e.st || ad !== e.ad) begin n_fail++; $display("FAIL mismatch_result: valid %0d status %h addr %h, required status %h addr %h", ok, st, ad, e.st, e.ad); end
    $display("mismatch job: status %h", st);
  endtask

  task automatic test_busy_hold();
    exp_t e; logic [7:0] st; logic [31:0] ad; bit ok;
    sb.push_back('{8'h00, 32'h0000_0240});
    run_job(32'h140, 18'h00338, 32'h240, 5, 5, 3'b000, 4'd8, 4'd3, 1'b1, 1'b1, 1'b0, 200);
    n_chk++; if (j_pb_cnt !== 1 || j_acc < 0 || j_pbs !== j_acc + 6) begin n_fail++; $display("FAIL busy_pb_start: pulses %0d at %0d, required 1 at %0d", j_pb_cnt, j_pbs, j_acc + 6); end
    n_chk++; if (j_pp_cnt !== 1 || j_pbi < 0 || j_pps !== j_pbi + 6) begin n_fail++; $display("FAIL busy_pp_start: pulses %0d at %0d, required 1 at %0d", j_pp_cnt, j_pps, j_pbi + 6); end
    take_result(st, ad, ok);
    e = sb.pop_front();
    n_chk++; if (!ok || st !== e.st || ad !== e.ad) begin n_fail++; $display("FAIL busy_result: valid %0d status %h addr %h, required status %h addr %h", ok, st, ad, e.st, e.ad); end
    $display("busy hold job: pb_start at +%0d, pp_start at +%0d", j_pbs - j_acc, j_pps - j_pbi);
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [7:0] st; logic [31:0] ad; bit ok;
    logic [31:0] addr, hdr; logic [17:0] cfg; logic [2:0] fl; logic [3:0] cnt, typ;
    for (int k = 0; k < 5; k++) begin
      addr = $urandom; hdr = $urandom; cfg = 18'($urandom); fl = 3'($urandom);
      cnt = (k % 2 == 0) ? cfg[3:0] : 4'($urandom);
      typ = (k % 2 == 0) ? cfg[7:4] : 4'($urandom);
      sb.push_back('{model_status(cfg, fl, cnt, typ), hdr});
      run_job(addr, cfg, hdr, k % 3, (k + 1) % 3, fl, cnt, typ, 1'b1, 1'b1, 1'b0, 200);
      take_result(st, ad, ok);
      e = sb.pop_front();
      n_chk++; if (!ok || st !== e.st || ad !== e.ad) begin n_fail++; $display("FAIL b2b_result_%0d: valid %0d status %h addr %h, required status %h addr %h", k, ok, st, ad, e.st, e.ad); end
      n_chk++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_%0d: cmd_ready %b res_valid %b, required 1 0", k, cmd_ready, res_valid); end
      $display("b2b job %0d: cfg %h status %h addr %h", k, cfg, st, ad);
    end
  endtask

  task automatic test_watchdog();
    exp_t e; logic [7:0] st; logic [31:0] ad; bit ok;
`ifdef PKT_JOB_WDOG_EN
    sb.push_back('{8'h40, 32'h0});
    run_job(32'h300, 18'h00338, 32'h400, 0, 0, 3'b000, 4'd8, 4'd3, 1'b0, 1'b1, 1'b0, 200);
    n_chk++; if (j_pbs < 0 || j_rv !== j_pbs + 17 || j_pp_cnt !== 0) begin n_fail++; $display("FAIL wdog_pb_timing: res_valid %0d pp_starts %0d, required %0d and 0", j_rv, j_pp_cnt, j_pbs + 17); end
    take_result(st, ad, ok);
    e = sb.pop_front();
    n_chk++; if (!ok || st !== e.st || ad !== e.ad) begin n_fail++; $display("FAIL wdog_pb_result: valid %0d status %h addr %h, required status %h addr %h", ok, st, ad, e.st, e.ad); end
    $display("pb timeout job: status %h addr %h", st, ad);
    sb.push_back('{8'hC0, 32'h0000_0500});
    run_job(32'h310, 18'h00338, 32'h500, 0, 0, 3'b000, 4'd8, 4'd3, 1'b1, 1'b0, 1'b0, 200);
    n_chk++; if (j_pps < 0 || j_rv !== j_pps + 17) begin n_fail++; $display("FAIL wdog_pp_timing: res_valid %0d, required %0d", j_rv, j_pps + 17); end
    take_result(st, ad, ok);
    e = sb.pop_front();
    n_chk++; if (!ok || st !== e.st || ad !== e.ad) begin n_fail++; $display("FAIL wdog_pp_result: valid %0d status %h addr %h, required status %h addr %h", ok, st, ad, e.st, e.ad); end
    $display("pp timeout job: status %h addr %h", st, ad);
`else
    run_job(32'h300, 18'h00338, 32'h400, 0, 0, 3'b000, 4'd8, 4'd3, 1'b0, 1'b1, 1'b0, 60);
    n_chk++; if (j_rv !== -1 || j_pb_cnt !== 1 || j_pp_cnt !== 0) begin n_fail++; $display("FAIL nowdog_wait: res_valid at %0d pb %0d pp %0d, required none 1 0", j_rv, j_pb_cnt, j_pp_cnt); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL nowdog_recover: cmd_ready %b, required 1", cmd_ready); end
    $display("no-watchdog job: still waiting after 60 cycles, recovered by reset");
`endif
  endtask

  task automatic test_backpressure_reset();
    exp_t e; logic [7:0] st; logic [31:0] ad; bit ok;
    sb.push_back('{8'h00, 32'h0000_0650});
    run_job(32'h600, 18'h00338, 32'h650, 0, 0, 3'b000, 4'd8, 4'd3, 1'b1, 1'b1, 1'b0, 200);
    e = sb[0];
    for (int i = 0; i < 10; i++) begin
      n_chk++; if (res_valid !== 1'b1 || res_status !== e.st || res_addr !== e.ad || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL hold_%0d: valid %b status %h addr %h ready %b, required 1 %h %h 0", i, res_valid, res_status, res_addr, cmd_ready, e.st, e.ad); end
      @(negedge clk);
    end
    take_result(st, ad, ok);
    e = sb.pop_front();
    n_chk++; if (!ok || st !== e.st || ad !== e.ad) begin n_fail++; $display("FAIL hold_result: valid %0d status %h addr %h, required status %h addr %h", ok, st, ad, e.st, e.ad); end
    $display("backpressure job: status %h addr %h", st, ad);
    run_job(32'h700, 18'h20338, 32'h750, 0, 0, 3'b000, 4'd8, 4'd3, 1'b1, 1'b0, 1'b1, 200);
    n_chk++; if (j_pps < 0 || pp_addr_hdr !== 32'h750) begin n_fail++; $display("FAIL midjob_reach_pp: pp_start %0d hdr %h, required started and 00000750", j_pps, pp_addr_hdr); end
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if ({cmd_ready, pb_start, pp_start, res_valid, pp_ignore_ecc_err} !== 5'b0) begin n_fail++; $display("FAIL midjob_reset_ctrl: got %b, required 00000", {cmd_ready, pb_start, pp_start, res_valid, pp_ignore_ecc_err}); end
    n_chk++; if (pb_addr_in !== 0 || pb_cfg !== 0 || pp_addr_hdr !== 0 || res_status !== 0 || res_addr !== 0) begin n_fail++; $display("FAIL midjob_reset_data: got %h %h %h %h %h, required all 0", pb_addr_in, pb_cfg, pp_addr_hdr, res_status, res_addr); end
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL midjob_after_reset: cmd_ready %b res_valid %b, required 1 0", cmd_ready, res_valid); end
    $display("reset during PP_WAIT: outputs cleared");
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_cfg = '0;
    pb_busy = 1'b0; pb_irq = 1'b0; pb_addr_out = '0;
    pp_busy = 1'b0; pp_irq = 1'b0; pp_pkt_flags = '0; pp_pkt_byte_cnt = '0; pp_pkt_type = '0;
    res_ready = 1'b0;
    test_reset();
    test_clean();
    test_inject();
    test_mismatch();
    test_busy_hold();
    test_back_to_back();
    test_watchdog();
    test_backpressure_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "global timeout");
  end

endmodule
